// File: rtl/mc_datapath.sv
// Multi-cycle datapath: 4-cycle FETCH/DECODE/EXEC/WB sequencer with a register file and a MIPS-like ALU.
// Optional ALU status flags (N, Z, C, V) are compiled in with `define MC_DATAPATH_FLAGS_EN.
module mc_datapath #(
    parameter int WIDTH      = 32,
    parameter int REG_COUNT  = 32,
    parameter int IMEM_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    input  logic                          im_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] im_addr,
    input  logic [31:0]                   im_wdata,
    output logic [WIDTH-1:0]              Dout,
    output logic [31:0]                   PC_out,
    output logic                          busy,
    output logic                          halted,
    output logic                          N,
    output logic                          Z,
    output logic                          C,
    output logic                          V
);

    localparam int          AW      = $clog2(IMEM_DEPTH);
    localparam int          RW      = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam logic [31:0] PC_MASK = 32'(IMEM_DEPTH * 4 - 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_HALT  = 6'h3F;
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    localparam logic [5:0] F_NOR    = 6'h27;
    localparam logic [5:0] F_SLT    = 6'h2A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t           state;
    logic [31:0]      imem [IMEM_DEPTH];
    logic [WIDTH-1:0] regs [REG_COUNT];
    logic [31:0]      ir;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             wb_en;
    logic [4:0]       wb_dst;

    logic [5:0]       opcode, funct;
    logic [4:0]       rs, rt, rd;
    logic [WIDTH-1:0] imm_ext;
    logic             is_sub, is_addi;
    logic [WIDTH-1:0] add_b, add_res;
    logic             add_cin;
    logic [WIDTH-1:0] alu_res;
    logic             alu_we;
    logic [4:0]       alu_dst;
    logic             unused_shamt;

    assign opcode       = ir[31:26];
    assign rs           = ir[25:21];
    assign rt           = ir[20:16];
    assign rd           = ir[15:11];
    assign funct        = ir[5:0];
    assign unused_shamt = ^ir[10:6];
    assign imm_ext      = WIDTH'($signed(ir[15:0]));

    // One shared adder serves add, sub (A + ~B + 1) and addi.
    assign is_sub  = (opcode == OP_RTYPE) && (funct == F_SUB);
    assign is_addi = (opcode == OP_ADDI);
    assign add_b   = is_sub ? ~b_q : (is_addi ? imm_ext : b_q);
    assign add_cin = is_sub;

`ifdef MC_DATAPATH_FLAGS_EN
    logic [WIDTH:0] add_sum;
    logic           add_cout;
    assign add_sum  = {1'b0, a_q} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    assign add_res  = add_sum[WIDTH-1:0];
    assign add_cout = add_sum[WIDTH];
`else
    assign add_res = a_q + add_b + {{(WIDTH-1){1'b0}}, add_cin};
`endif

    function automatic logic rf_valid(input logic [4:0] idx);
        return (idx != 5'd0) && (int'(idx) < REG_COUNT);
    endfunction

    function automatic logic [WIDTH-1:0] rf_read(input logic [4:0] idx);
        return rf_valid(idx) ? regs[idx[RW-1:0]] : '0;
    endfunction

    // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
    always_comb begin
        alu_res = '0;
        alu_we  = 1'b0;
        alu_dst = rd;
        if (opcode == OP_RTYPE) begin
            case (funct)
                F_ADD, F_SUB: begin alu_res = add_res;             alu_we = 1'b1; end
                F_AND:        begin alu_res = a_q & b_q;           alu_we = 1'b1; end
                F_OR:         begin alu_res = a_q | b_q;           alu_we = 1'b1; end
                F_NOR:        begin alu_res = ~(a_q | b_q);        alu_we = 1'b1; end
                F_SLT:        begin
                    alu_res = ($signed(a_q) < $signed(b_q)) ? WIDTH'(1) : '0;
                    alu_we  = 1'b1;
                end
                default: ;
            endcase
        end else if (opcode == OP_ADDI) begin
            alu_res = add_res;
            alu_we  = 1'b1;
            alu_dst = rt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            PC_out <= '0;
            Dout   <= '0;
            ir     <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            wb_en  <= 1'b0;
            wb_dst <= '0;
            busy   <= 1'b0;
            halted <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    ir    <= imem[PC_out[AW+1:2]];
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    a_q <= rf_read(rs);
                    b_q <= rf_read(rt);
                    if (opcode == OP_HALT) begin
                        state  <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_q  <= alu_res;
                    wb_en  <= alu_we;
                    wb_dst <= alu_dst;
                    state  <= S_WB;
                end
                S_WB: begin
                    if (wb_en) begin
                        if (rf_valid(wb_dst)) regs[wb_dst[RW-1:0]] <= res_q;
                        Dout <= res_q;
                    end
                    PC_out <= (PC_out + 32'd4) & PC_MASK;
                    state  <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: instruction memory is deliberately not reset; a loaded program survives reset.
    always_ff @(posedge clk) begin
        if (im_we && (state == S_IDLE)) imem[im_addr] <= im_wdata;
    end

`ifdef MC_DATAPATH_FLAGS_EN
    logic flag_upd;
    logic n_q, z_q, c_q, v_q;

    assign flag_upd = is_addi || is_sub || ((opcode == OP_RTYPE) && (funct == F_ADD));

    always_ff @(posedge clk) begin
        if (reset) begin
            n_q <= 1'b0;
            z_q <= 1'b0;
            c_q <= 1'b0;
            v_q <= 1'b0;
        end else if ((state == S_EXEC) && flag_upd) begin
            n_q <= add_res[WIDTH-1];
            z_q <= (add_res == '0);
            c_q <= add_cout;
            // Overflow: both adder operands share a sign that the sum does not.
            v_q <= (a_q[WIDTH-1] == add_b[WIDTH-1]) && (add_res[WIDTH-1] != a_q[WIDTH-1]);
        end
    end

    assign N = n_q;
    assign Z = z_q;
    assign C = c_q;
    assign V = v_q;
`else
    assign N = 1'b0;
    assign Z = 1'b0;
    assign C = 1'b0;
    assign V = 1'b0;
`endif

endmodule
